// File: rtl/noc_pkg.sv
// noc_pkg: shared flit width constants, flit types and destination helper for the ring network
package noc_pkg;
  localparam int FLIT_W = 16;
  localparam int ID_W = 6;
  localparam int PAYLOAD_W = FLIT_W - ID_W;
  typedef logic [FLIT_W-1:0] flit_t;
  typedef struct packed {
    logic [ID_W-1:0]      dest;
    logic [PAYLOAD_W-1:0] payload;
  } flit_s_t;
  function automatic logic [ID_W-1:0] flit_dest(input flit_t f);
    return f[FLIT_W-1 -: ID_W];
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: first-word-fall-through flit FIFO with full/empty flags and synchronous reset
module noc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_pop, do_push;
  always_comb begin
    full = cnt == (AW+1)'(DEPTH);
    empty = cnt == '0;
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    dout = mem[rp];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/noc_ring_stop.sv
// noc_ring_stop: ring stop that injects GPU flits, ejects flits addressed to NODE_ID and forwards the rest
module noc_ring_stop import noc_pkg::*; #(
  parameter int NODE_ID = 14,
  parameter int ID_W = 6,
  parameter int FLIT_W = 16,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [FLIT_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [FLIT_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  input  logic [FLIT_W-1:0] ring_data_in,
  input  logic              ring_valid_in,
  output logic              ring_ready_out,
  output logic [FLIT_W-1:0] ring_data_out,
  output logic              ring_valid_out,
  input  logic              ring_ready_in,
  output logic [15:0]       stat_inj,
  output logic [15:0]       stat_ej,
  output logic [15:0]       stat_pass
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [FLIT_W-1:0] inj_head;
  logic              inj_full, inj_empty, ej_full, ej_empty;
  logic              is_local, out_free, t_req, i_req, grant_inj, grant_transit, ej_push, ej_pop;
  logic [SW-1:0]     starve;
  always_comb begin
    is_local = flit_dest(flit_t'(ring_data_in)) == ID_W'(NODE_ID);
    out_free = !ring_valid_out | ring_ready_in;
    t_req = ring_valid_in & !is_local;
    i_req = !inj_empty;
    grant_inj = out_free & i_req & (!t_req | starve == SW'(STARVE_LIMIT));
    grant_transit = out_free & t_req & !grant_inj;
    gpu_ready_out = !ARESET & !inj_full;
    ring_ready_out = !ARESET & ring_valid_in & (is_local ? !ej_full : grant_transit);
    ej_push = ring_valid_in & ring_ready_out & is_local;
    gpu_valid_out = !ej_empty;
    ej_pop = gpu_valid_out & gpu_ready_in;
  end
  noc_flit_fifo #(.DEPTH(INJ_DEPTH), .W(FLIT_W)) u_inj (
    .clk(ACLK), .rst(ARESET), .push(gpu_valid_in & gpu_ready_out), .din(gpu_data_in),
    .pop(grant_inj), .dout(inj_head), .full(inj_full), .empty(inj_empty)
  );
  noc_flit_fifo #(.DEPTH(EJ_DEPTH), .W(FLIT_W)) u_ej (
    .clk(ACLK), .rst(ARESET), .push(ej_push), .din(ring_data_in),
    .pop(ej_pop), .dout(gpu_data_out), .full(ej_full), .empty(ej_empty)
  );
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ring_valid_out <= 1'b0;
      ring_data_out <= '0;
      starve <= '0;
      stat_inj <= '0;
      stat_ej <= '0;
      stat_pass <= '0;
    end else begin
      if (out_free) begin
        ring_valid_out <= grant_inj | grant_transit;
        ring_data_out <= grant_inj ? inj_head : grant_transit ? ring_data_in : ring_data_out;
      end
      starve <= grant_inj ? '0 : (out_free & t_req & i_req) ? starve + 1'b1 : starve;
      if (grant_inj) stat_inj <= stat_inj + 1'b1;
      if (ej_pop) stat_ej <= stat_ej + 1'b1;
      if (grant_transit) stat_pass <= stat_pass + 1'b1;
    end
  end
endmodule
